// File: rtl/alt_vipvfr121_read_burst_scheduler.sv
// ---------------------------------------------------------------------------
// alt_vipvfr121_read_burst_scheduler
//
// Issues the Avalon-MM burst reads that fill the frame reader's packed-word
// FIFO. For each frame it walks from base_addr in bursts of at most BURST_MAX
// words. Before each command it reserves room in the FIFO, so returned data
// can never overflow the FIFO. At frame end, or after an abort, it waits for
// every in-flight word to be returned and consumed. It then pulses
// unpack_clear and reports completion with a one-cycle done pulse.
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            one-cycle frame start, accepted only while idle
//   base_addr        frame byte address, sampled on an accepted start
//   frame_words      words in the frame, sampled on an accepted start
//   abort            one-cycle request to stop the current frame
//   busy             high from the accepted start until done
//   done             one-cycle end-of-frame pulse
//   aborted          qualifies done: the frame was aborted
//   av_address       burst start byte address
//   av_burstcount    burst length in words
//   av_read          read command, held while av_waitrequest is high
//   av_waitrequest   slave stall
//   av_readdatavalid one returned word, written into the FIFO
//   word_consumed    unpacker popped one word from the FIFO
//   unpack_clear     one-cycle pulse to the unpacker's clear input
// ---------------------------------------------------------------------------
module alt_vipvfr121_read_burst_scheduler #(
   parameter int ADDR_WIDTH     = 32,
   parameter int BYTES_PER_WORD = 16,
   parameter int BURST_MAX      = 32,
   parameter int FIFO_DEPTH     = 64,
   parameter int WORDS_WIDTH    = 24
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
   input  logic [WORDS_WIDTH-1:0]        frame_words,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          aborted,
   output logic [ADDR_WIDTH-1:0]         av_address,
   output logic [$clog2(BURST_MAX):0]    av_burstcount,
   output logic                          av_read,
   input  logic                          av_waitrequest,
   input  logic                          av_readdatavalid,
   input  logic                          word_consumed,
   output logic                          unpack_clear
);

   localparam int BC_W  = $clog2(BURST_MAX) + 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // ST_FINISH is the cycle in which unpack_clear is high; done follows it.
   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_ISSUE       = 3'd1;
   localparam logic [2:0] ST_WAIT_ACCEPT = 3'd2;
   localparam logic [2:0] ST_DRAIN       = 3'd3;
   localparam logic [2:0] ST_CLEAR       = 3'd4;
   localparam logic [2:0] ST_FINISH      = 3'd5;

   logic [2:0]             state_r;
   logic [WORDS_WIDTH-1:0] remaining_r;
   logic [ADDR_WIDTH-1:0]  addr_r;
   logic [CNT_W-1:0]       outstanding_r;
   logic [CNT_W-1:0]       occupancy_r;
   logic                   abort_flag_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   aborted_r;
   logic                   av_read_r;
   logic [ADDR_WIDTH-1:0]  av_address_r;
   logic [BC_W-1:0]        av_burstcount_r;
   logic                   unpack_clear_r;

   logic [BC_W-1:0]        len_s;
   logic [CNT_W:0]         credit_sum_s;
   logic                   credit_ok_s;
   logic                   accept_s;
   logic                   abort_pending_s;
   logic                   rdv_dec_s;
   logic                   cons_dec_s;
   logic [CNT_W-1:0]       inc_s;
   logic [CNT_W-1:0]       outstanding_nxt_s;
   logic [CNT_W-1:0]       occupancy_nxt_s;
   logic [WORDS_WIDTH-1:0] remaining_after_s;
   logic [ADDR_WIDTH-1:0]  addr_step_s;

   // Length of the next burst: a full burst, or the tail of the frame.
   always_comb begin
      len_s = {BC_W{1'b0}};
      if (remaining_r >= WORDS_WIDTH'(BURST_MAX)) begin
         len_s = BC_W'(BURST_MAX);
      end else begin
         len_s = remaining_r[BC_W-1:0];
      end
   end

   // Credit check: the burst must fit next to everything already reserved.
   always_comb begin
      credit_sum_s = {1'b0, occupancy_r} + (CNT_W + 1)'(len_s);
      credit_ok_s  = 1'b0;
      if (credit_sum_s <= (CNT_W + 1)'(FIFO_DEPTH)) begin
         credit_ok_s = 1'b1;
      end else begin
         credit_ok_s = 1'b0;
      end
   end

   assign accept_s          = (state_r == ST_WAIT_ACCEPT) && av_read_r && !av_waitrequest;
   assign abort_pending_s   = abort_flag_r | abort;
   // Decrements are guarded so stray strobes (e.g. data still returning
   // after a reset) cannot wrap the counters below zero.
   assign rdv_dec_s         = av_readdatavalid && (outstanding_r != {CNT_W{1'b0}});
   assign cons_dec_s        = word_consumed && (occupancy_r != {CNT_W{1'b0}});
   assign remaining_after_s = remaining_r - WORDS_WIDTH'(av_burstcount_r);
   assign addr_step_s       = ADDR_WIDTH'(av_burstcount_r) * ADDR_WIDTH'(BYTES_PER_WORD);

   // Net next value of both counters; an accepted burst is reserved at once.
   always_comb begin
      inc_s = {CNT_W{1'b0}};
      if (accept_s) begin
         inc_s = CNT_W'(av_burstcount_r);
      end else begin
         inc_s = {CNT_W{1'b0}};
      end
      outstanding_nxt_s = outstanding_r + inc_s - CNT_W'(rdv_dec_s);
      occupancy_nxt_s   = occupancy_r + inc_s - CNT_W'(cons_dec_s);
   end

   // In-flight and reserved word counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding_r <= {CNT_W{1'b0}};
         occupancy_r   <= {CNT_W{1'b0}};
      end else begin
         outstanding_r <= outstanding_nxt_s;
         occupancy_r   <= occupancy_nxt_s;
      end
   end

   // Frame sequencer and registered Avalon / status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= ST_IDLE;
         remaining_r     <= {WORDS_WIDTH{1'b0}};
         addr_r          <= {ADDR_WIDTH{1'b0}};
         abort_flag_r    <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         aborted_r       <= 1'b0;
         av_read_r       <= 1'b0;
         av_address_r    <= {ADDR_WIDTH{1'b0}};
         av_burstcount_r <= {BC_W{1'b0}};
         unpack_clear_r  <= 1'b0;
      end else begin
         done_r         <= 1'b0;
         aborted_r      <= 1'b0;
         unpack_clear_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  busy_r       <= 1'b1;
                  remaining_r  <= frame_words;
                  addr_r       <= base_addr;
                  abort_flag_r <= 1'b0;
                  if (frame_words == {WORDS_WIDTH{1'b0}}) begin
                     state_r <= ST_CLEAR;
                  end else begin
                     state_r <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (abort) begin
                  abort_flag_r <= 1'b1;
                  state_r      <= ST_DRAIN;
               end else if (credit_ok_s) begin
                  av_read_r       <= 1'b1;
                  av_address_r    <= addr_r;
                  av_burstcount_r <= len_s;
                  state_r         <= ST_WAIT_ACCEPT;
               end
            end
            ST_WAIT_ACCEPT: begin
               // The command stays up until accepted, even if aborted.
               if (abort) begin
                  abort_flag_r <= 1'b1;
               end
               if (accept_s) begin
                  av_read_r   <= 1'b0;
                  remaining_r <= remaining_after_s;
                  addr_r      <= addr_r + addr_step_s;
                  if ((remaining_after_s != {WORDS_WIDTH{1'b0}}) && !abort_pending_s) begin
                     state_r <= ST_ISSUE;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  abort_flag_r <= 1'b1;
               end
               if ((outstanding_r == {CNT_W{1'b0}}) && (occupancy_r == {CNT_W{1'b0}})) begin
                  state_r <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (abort) begin
                  abort_flag_r <= 1'b1;
               end
               unpack_clear_r <= 1'b1;
               state_r        <= ST_FINISH;
            end
            ST_FINISH: begin
               done_r       <= 1'b1;
               aborted_r    <= abort_pending_s;
               busy_r       <= 1'b0;
               abort_flag_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
            default: begin
               state_r      <= ST_IDLE;
               busy_r       <= 1'b0;
               av_read_r    <= 1'b0;
               abort_flag_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign aborted       = aborted_r;
   assign av_read       = av_read_r;
   assign av_address    = av_address_r;
   assign av_burstcount = av_burstcount_r;
   assign unpack_clear  = unpack_clear_r;

endmodule

// File: tb/tb_alt_vipvfr121_read_burst_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for alt_vipvfr121_read_burst_scheduler. A per-cycle task models the
// Avalon slave (waitrequest, delayed readdatavalid) and the FIFO consumer.
// Accepted bursts are compared with the list that frame arithmetic predicts.
// ---------------------------------------------------------------------------
module tb_alt_vipvfr121_read_burst_scheduler;

   localparam int BMAX  = 32;
   localparam int BPW   = 16;
   localparam int DEPTH = 64;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [31:0] base_addr;
   logic [23:0] frame_words;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [31:0] av_address;
   logic [5:0]  av_burstcount;
   logic        av_read;
   logic        av_waitrequest;
   logic        av_readdatavalid;
   logic        word_consumed;
   logic        unpack_clear;

   alt_vipvfr121_read_burst_scheduler dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .base_addr        (base_addr),
      .frame_words      (frame_words),
      .abort            (abort),
      .busy             (busy),
      .done             (done),
      .aborted          (aborted),
      .av_address       (av_address),
      .av_burstcount    (av_burstcount),
      .av_read          (av_read),
      .av_waitrequest   (av_waitrequest),
      .av_readdatavalid (av_readdatavalid),
      .word_consumed    (word_consumed),
      .unpack_clear     (unpack_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // environment knobs
   int wr_mode = 0;      // 0 never stall, 1 random, 2 hold burst hold_idx
   int hold_idx = 0;
   int hold_left = 0;
   int cons_mode = 0;    // 0 always, 1 idle, 2 random, 3 budgeted
   int cons_budget = 0;
   int rdv_pct = 100;

   // model state
   int          cyc = 0;
   int          ret_pending = 0;   // accepted, not yet returned
   int          fifo_fill = 0;     // returned, not yet consumed
   int          reserved = 0;      // accepted, not yet consumed
   logic [31:0] acc_addr[$];
   int          acc_len[$];
   int          clear_cnt, clear_cyc, done_cnt, done_cyc, stall_cnt;
   logic        done_aborted, busy_at_done, drained_at_clear;
   logic        stalled_prev = 1'b0;
   logic [31:0] prev_addr;
   logic [5:0]  prev_bc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe outputs after the edge, then drive next inputs.
   task automatic tick();
      logic wr, acc, rdv, c;
      @(negedge clock);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (unpack_clear) begin
         clear_cnt++;
         clear_cyc = cyc;
         drained_at_clear = (reserved == 0) && (fifo_fill == 0) && (ret_pending == 0);
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         done_aborted = aborted;
         busy_at_done = busy;
      end
      if (stalled_prev) begin
         check("hold_read", av_read, 1);
         check("hold_addr", av_address, prev_addr);
         check("hold_bc", av_burstcount, prev_bc);
      end
      case (wr_mode)
         1: wr = ($urandom_range(0, 2) == 0);
         2: begin
            if (av_read && (acc_len.size() == hold_idx) && (hold_left > 0)) begin
               wr = 1'b1;
               hold_left--;
            end else begin
               wr = 1'b0;
            end
         end
         default: wr = 1'b0;
      endcase
      av_waitrequest = wr;
      acc = av_read && !wr;
      if (av_read && wr) stall_cnt++;
      stalled_prev = av_read && wr;
      prev_addr    = av_address;
      prev_bc      = av_burstcount;
      if (acc) begin
         check("credit", (reserved + int'(av_burstcount)) <= DEPTH, 1);
         acc_addr.push_back(av_address);
         acc_len.push_back(int'(av_burstcount));
         reserved += int'(av_burstcount);
      end
      case (cons_mode)
         0: c = (fifo_fill > 0);
         2: c = (fifo_fill > 0) && ($urandom_range(0, 3) != 0);
         3: c = (fifo_fill > 0) && (cons_budget > 0);
         default: c = 1'b0;
      endcase
      rdv = (ret_pending > 0) && ($urandom_range(0, 99) < rdv_pct);
      av_readdatavalid = rdv;
      word_consumed    = c;
      if (c) begin
         fifo_fill--;
         reserved--;
         if (cons_mode == 3) cons_budget--;
      end
      if (rdv) begin
         ret_pending--;
         fifo_fill++;
      end
      if (acc) ret_pending += int'(av_burstcount);
   endtask

   task automatic start_frame(input logic [31:0] b, input int w);
      acc_addr.delete();
      acc_len.delete();
      clear_cnt = 0; done_cnt = 0; stall_cnt = 0;
      clear_cyc = -10; done_cyc = -20;
      base_addr   = b;
      frame_words = 24'(w);
      start       = 1'b1;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while ((done_cnt == 0) && (n < bound)) begin
         tick();
         n++;
      end
      check("done_seen", done_cnt, 1);
   endtask

   // Frame-end bookkeeping common to every completed frame.
   task automatic check_end(input logic exp_abort);
      check("clear_once", clear_cnt, 1);
      check("done_after_clear", done_cyc - clear_cyc, 1);
      check("drained_at_clear", drained_at_clear, 1);
      check("aborted", done_aborted, exp_abort);
      check("busy_at_done", busy_at_done, 0);
   endtask

   task automatic check_bursts(input logic [31:0] b, input int w, input int nexp);
      logic [31:0] ea;
      int rem, el;
      check("burst_count", acc_len.size(), nexp);
      for (int i = 0; (i < nexp) && (i < acc_len.size()); i++) begin
         rem = w - BMAX * i;
         el  = (rem > BMAX) ? BMAX : rem;
         ea  = b + 32'(i * BMAX * BPW);
         check("burst_len", acc_len[i], el);
         check("burst_addr", acc_addr[i], ea);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b;
      int w, n;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0;
      base_addr = 32'd0; frame_words = 24'd0;
      av_waitrequest = 1'b0; av_readdatavalid = 1'b0; word_consumed = 1'b0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_read", av_read, 0);
      check("rst_addr", av_address, 0);
      check("rst_bc", av_burstcount, 0);
      check("rst_clear", unpack_clear, 0);
      reset_n = 1'b1;
      tick();

      // 100-word frame, no stalls, consumer always ready
      wr_mode = 0; cons_mode = 0; rdv_pct = 100;
      start_frame(32'h1000_0000, 100);
      tick();
      check("busy_n1", busy, 1);
      check("read_n1", av_read, 0);
      tick();
      check("read_n2", av_read, 1);
      check("addr_n2", av_address, 32'h1000_0000);
      check("bc_n2", av_burstcount, 32);
      wait_done(2000);
      check_bursts(32'h1000_0000, 100, 4);
      check_end(1'b0);

      // credit stall: consumer idle on a 128-word frame
      cons_mode = 1;
      start_frame(32'h0000_4000, 128);
      repeat (80) tick();
      check("stall_bursts", acc_len.size(), 2);
      check("stall_read_low", av_read, 0);
      cons_mode = 3; cons_budget = 31;
      n = 0;
      while ((cons_budget > 0) && (n < 100)) begin tick(); n++; end
      repeat (20) tick();
      check("stall_after_31", acc_len.size(), 2);
      cons_budget = 1;
      n = 0;
      while ((acc_len.size() < 3) && (n < 30)) begin tick(); n++; end
      check("third_burst", acc_len.size(), 3);
      cons_mode = 0;
      wait_done(2000);
      check_bursts(32'h0000_4000, 128, 4);
      check_end(1'b0);

      // waitrequest held 5 cycles on the second burst
      wr_mode = 2; hold_idx = 1; hold_left = 5;
      start_frame(32'h2000_0100, 100);
      wait_done(2000);
      check("hold_cycles", stall_cnt, 5);
      check_bursts(32'h2000_0100, 100, 4);
      check_end(1'b0);

      // abort while the second command is held
      wr_mode = 2; hold_idx = 1; hold_left = 8; cons_mode = 2; rdv_pct = 80;
      start_frame(32'h3000_0000, 200);
      n = 0;
      while (!(av_read && (acc_len.size() == 1) && (stall_cnt >= 3)) && (n < 300)) begin
         tick(); n++;
      end
      check("abort_setup", av_read && (acc_len.size() == 1), 1);
      abort = 1'b1;
      wait_done(3000);
      check("abort_hold_done", stall_cnt, 8);
      check_bursts(32'h3000_0000, 200, 2);
      check_end(1'b1);

      // zero-word frame
      wr_mode = 0; cons_mode = 0; rdv_pct = 100;
      start_frame(32'h5555_0000, 0);
      tick();
      check("z_busy", busy, 1);
      check("z_clear_early", unpack_clear, 0);
      tick();
      check("z_clear", unpack_clear, 1);
      check("z_done_early", done, 0);
      tick();
      check("z_done", done, 1);
      check("z_busy_low", busy, 0);
      check("z_aborted", aborted, 0);
      check("z_no_read", acc_len.size(), 0);

      // reset while the second command is held
      wr_mode = 2; hold_idx = 1; hold_left = 30;
      start_frame(32'h0700_0000, 100);
      n = 0;
      while (!(av_read && (acc_len.size() == 1)) && (n < 100)) begin tick(); n++; end
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_read", av_read, 0);
      check("mid_rst_addr", av_address, 0);
      check("mid_rst_bc", av_burstcount, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_clear", unpack_clear, 0);
      stalled_prev = 1'b0; reserved = 0; fifo_fill = 0;
      tick();
      reset_n = 1'b1;
      wr_mode = 0; cons_mode = 1;
      repeat (40) tick();   // stale readdatavalid from before the reset
      fifo_fill = 0; ret_pending = 0;
      check("stale_idle", busy, 0);

      // randomized frames, with a start issued mid-frame that must be dropped
      wr_mode = 1; cons_mode = 2; rdv_pct = 70;
      for (int it = 0; it < 5; it++) begin
         b = (it == 0) ? 32'hFFFF_FE00 + $urandom_range(0, 255) : $urandom;
         w = $urandom_range(40, 300);
         start_frame(b, w);
         repeat (10) tick();
         check("rnd_busy", busy, 1);
         start = 1'b1; base_addr = $urandom; frame_words = 24'($urandom_range(1, 99));
         wait_done(6000);
         check_bursts(b, w, (w + BMAX - 1) / BMAX);
         check_end(1'b0);
         repeat (5) tick();
         check("rnd_idle", busy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
